ram8_arbiter: RTL and testbench
===============================

# ram8_arbiter

Two-port arbiter and sequencer in front of the 8-word x 16-bit register RAM. Two requesters (A, B) each issue single-word read or write transactions. The block serializes them onto the single RAM port (data in, load, 3-bit address, data out) and returns a one-cycle acknowledge plus registered read data to the winner. It sits between the CPU-side/IO-side masters and the RAM8 instance.

## Interface
Parameters: none. Widths are fixed at 16-bit data and 3-bit address to match RAM8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_a / req_b  in  1  transaction request; held high until the matching ack.
- we_a / we_b  in  1  1 = write, 0 = read; stable while req is high.
- addr_a / addr_b  in  3  word address; stable while req is high.
- wdata_a / wdata_b  in  16  write data; stable while req is high.
- ack_a / ack_b  out  1  one-cycle completion pulse.
- rdata_a / rdata_b  out  16  registered read data; valid in the ack cycle, held until that port's next ack.
- ram_in  out  16  to RAM8 `in`.
- ram_load  out  1  to RAM8 `load`.
- ram_address  out  3  to RAM8 `address`.
- ram_out  in  16  from RAM8 `out`; combinational read of `ram_address`.
- busy  out  1  high in ACCESS and RESP.
- grant_b  out  1  0 = A owns the current or last transaction, 1 = B.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, any request: choose the winner, latch its we, addr and wdata into we_q, addr_q, wdata_q, set grant_b, then go to ACCESS.
- ACCESS: drive ram_address = addr_q, ram_in = wdata_q, ram_load = we_q & ~reset. At the clock edge:
  - load rdata_<winner> from ram_out;
  - update last_grant;
  - go to RESP with ack_<winner> = 1.
- RESP: ack_<winner> = 1 for exactly this cycle, then go to IDLE.
- Outside ACCESS:
  - ram_load = 0;
  - ram_address and ram_in hold the latched values, which avoids glitching the RAM mux.
- A write's rdata returns the word's contents before the write (read-before-write), because RAM8 updates at the end of ACCESS.
- The loser's request stays pending. It is evaluated again in the next IDLE cycle.
- Requesters must drop req no later than the edge that ends RESP. A req still high when IDLE samples it is a new transaction.
- The FSM has no illegal states. Any unencoded state goes to IDLE on the next edge.

## Timing
- Reset (synchronous): state = IDLE; last_grant = B, so A wins the first tie.
- Reset values of outputs: ack_a = ack_b = 0, rdata_a = rdata_b = 0, ram_in = 0, ram_address = 0, ram_load = 0, busy = 0, grant_b = 0.
- Latency: req sampled at edge n (IDLE -> ACCESS); RAM write and rdata capture at edge n+1; ack high from n+1 to n+2; FSM back in IDLE after n+2.
- Throughput: one transaction per 3 cycles. Back-to-back requests alternate under round-robin.
- Reset asserted in ACCESS: ram_load is forced to 0, so no write occurs. The FSM goes to IDLE and no ack is issued.
- Reset asserted in RESP: ack drops at the edge. rdata is cleared to 0.
- A req deasserted mid-transaction is ignored, because the transaction was already latched and completes.

## Configuration
- `RAM8_ARB_RR_EN` defined: round-robin. On simultaneous requests the port that did not win last time is granted (the opposite of last_grant). last_grant updates on every completed ACCESS.
- `RAM8_ARB_RR_EN` undefined: fixed priority, A always wins ties. The last_grant register is not built. B is granted only when req_a = 0 in IDLE.

## Test plan
- Reset, then A writes 16'h1234 to addr 5: ram_load is high for exactly one cycle; ack_a pulses 2 edges after the req sample; rdata_a = 16'h0000 (old value).
- A reads addr 5: ack_a after 2 edges, rdata_a = 16'h1234. ack_b stays 0 throughout.
- req_a and req_b both held continuously with RR_EN defined, A reading addr 1 and B reading addr 2: grants go A, B, A, B, with ack pulses every 3 cycles. Without RR_EN: A is acked each time it re-requests, and B is served only when A is idle.
- Write 16'hBEEF via B to addr 7, then read via A from addr 7: rdata_a = 16'hBEEF; rdata_b holds its previous read-before-write value unchanged.
- Reset pulsed during ACCESS of an A write of 16'hFFFF to addr 3: ram_load stays 0, no ack, and a subsequent read of addr 3 returns 16'h0000.
- B requests while A's transaction is in ACCESS: B is not granted until the IDLE after A's RESP, so B's ack comes 3 cycles after A's.

Source files
------------

// File: rtl/ram8_arbiter.sv
// ram8_arbiter
//
// Two-port arbiter and sequencer in front of the 8-word x 16-bit RAM8.
// Requesters A and B each issue single-word read or write transactions.
// The block serializes them onto the single RAM port. It returns a one-cycle
// acknowledge and registered read data to the winner.
//
// Transaction timing: IDLE samples the requests and latches the winner.
// ACCESS drives the RAM for one cycle. The read data is captured, and a
// write lands, at the end of ACCESS. RESP raises the winner's ack for one
// cycle. Reads are read-before-write: a write returns the previous contents
// of the word.
//
// Configuration macro:
//   RAM8_ARB_RR_EN  defined   -> round-robin on ties. The port that did not
//                                win the last completed ACCESS is granted.
//                   undefined -> fixed priority. A always wins ties.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset
//   req_a / req_b       request, held until the matching ack
//   we_a / we_b         1 = write, 0 = read
//   addr_a / addr_b     3-bit word address
//   wdata_a / wdata_b   16-bit write data
//   ack_a / ack_b       one-cycle completion pulse, high in RESP
//   rdata_a / rdata_b   registered read data, held until that port's next ack
//   ram_in              to RAM8 in
//   ram_load            to RAM8 load, high only in ACCESS for a write
//   ram_address         to RAM8 address
//   ram_out             from RAM8 out, a combinational read of ram_address
//   busy                high in ACCESS and RESP
//   grant_b             owner of the current or last transaction (1 = B)

module ram8_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        we_a,
  input  logic        we_b,
  input  logic [2:0]  addr_a,
  input  logic [2:0]  addr_b,
  input  logic [15:0] wdata_a,
  input  logic [15:0] wdata_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b,
  output logic [15:0] ram_in,
  output logic        ram_load,
  output logic [2:0]  ram_address,
  input  logic [15:0] ram_out,
  output logic        busy,
  output logic        grant_b
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        we_q;
  logic [2:0]  addr_q;
  logic [15:0] wdata_q;
  logic        grant_b_q;
  logic        pick_b;     // winner chosen in IDLE (1 = B)
  logic        start;      // IDLE sees a request and launches a transaction

  assign start = (state == IDLE) && (req_a || req_b);

`ifdef RAM8_ARB_RR_EN
  // Last completed winner (1 = B). It resets to B so that A wins the first tie.
  logic last_grant;

  always_comb begin
    pick_b = req_b;
    if (req_a && req_b) begin
      pick_b = ~last_grant;
    end
  end
`else
  always_comb begin
    pick_b = req_b & ~req_a;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values. This is what makes the read-before-write
  // capture of ram_out line up with the RAM's own update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      addr_q    <= 3'd0;
      wdata_q   <= 16'd0;
      grant_b_q <= 1'b0;
      rdata_a   <= 16'd0;
      rdata_b   <= 16'd0;
`ifdef RAM8_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (start) begin
        grant_b_q <= pick_b;
        we_q      <= pick_b ? we_b    : we_a;
        addr_q    <= pick_b ? addr_b  : addr_a;
        wdata_q   <= pick_b ? wdata_b : wdata_a;
      end
      if (state == ACCESS) begin
        if (grant_b_q) begin
          rdata_b <= ram_out;
        end else begin
          rdata_a <= ram_out;
        end
`ifdef RAM8_ARB_RR_EN
        last_grant <= grant_b_q;
`endif
      end
    end
  end

  // NOTE: every signal written here gets a default before the case statement.
  // A path that forgets one would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    ack_a       = 1'b0;
    ack_b       = 1'b0;
    busy        = 1'b0;
    ram_load    = 1'b0;
    // The address and data stay on the latched values in every state, so the
    // RAM's mux inputs do not glitch between transactions.
    ram_address = addr_q;
    ram_in      = wdata_q;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        busy       = 1'b1;
        // Reset inside ACCESS must not let the pending write reach the RAM.
        ram_load   = we_q & ~reset;
        state_next = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        ack_a      = ~grant_b_q;
        ack_b      = grant_b_q;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign grant_b = grant_b_q;

endmodule

// File: tb/tb_ram8_arbiter.sv
// tb_ram8_arbiter
//
// Directed bench for ram8_arbiter. A behavioural RAM8 sits on the RAM port:
// a synchronous write on load and a combinational read of the address.
// Each scenario task drives requests at the falling edge and samples
// outputs at the falling edge. Expected values are written by hand.

module tb_ram8_arbiter;

  logic        clk;
  logic        reset;
  logic        req_a, req_b;
  logic        we_a, we_b;
  logic [2:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;
  logic        ack_a, ack_b;
  logic [15:0] rdata_a, rdata_b;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [2:0]  ram_address;
  logic [15:0] ram_out;
  logic        busy;
  logic        grant_b;

  int errors = 0;
  int checks = 0;

  // Preloaded words give reads something distinctive to return.
  logic [15:0] mem [8] = '{16'h0000, 16'h1111, 16'h2222, 16'h0000,
                           16'h0000, 16'h0000, 16'h0000, 16'h0707};

  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
  end
  assign ram_out = mem[ram_address];

  ram8_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_a       (req_a),
    .req_b       (req_b),
    .we_a        (we_a),
    .we_b        (we_b),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .wdata_a     (wdata_a),
    .wdata_b     (wdata_b),
    .ack_a       (ack_a),
    .ack_b       (ack_b),
    .rdata_a     (rdata_a),
    .rdata_b     (rdata_b),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_address (ram_address),
    .ram_out     (ram_out),
    .busy        (busy),
    .grant_b     (grant_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Issues one transaction on port A (pb=0) or B (pb=1) from a falling edge
  // with the FSM idle. It reports the ack latency in falling edges (-1 on
  // timeout), the read data returned, the number of cycles ram_load was seen
  // high, and the number of stray acks on the other port.
  task automatic do_txn(input bit pb, input logic we, input logic [2:0] addr,
                        input logic [15:0] wd, output int lat,
                        output logic [15:0] rd, output int loads,
                        output int other);
    lat = -1; rd = 16'hxxxx; loads = 0; other = 0;
    if (!pb) begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
    end else begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ram_load) loads++;
      if (pb ? ack_a : ack_b) other++;
      if (pb ? ack_b : ack_a) begin
        lat = i;
        rd  = pb ? rdata_b : rdata_a;
        req_a = 1'b0;
        req_b = 1'b0;
        break;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack_a, ack_b, rdata_a, rdata_b, ram_in, ram_address, ram_load, busy, grant_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b%b rdata_a=%h rdata_b=%h ram_in=%h addr=%0d load=%b busy=%b grant_b=%b, expected all zero",
               ack_a, ack_b, rdata_a, rdata_b, ram_in, ram_address, ram_load, busy, grant_b);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read_a();
    int lat, loads, other;
    logic [15:0] rd;
    do_txn(1'b0, 1'b1, 3'd5, 16'h1234, lat, rd, loads, other);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL write_a_latency: got %0d expected 2", lat); end
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL write_a_rdata: got %h expected 0000", rd); end
    checks++;
    if (loads !== 1) begin errors++; $display("FAIL write_a_load_cycles: got %0d expected 1", loads); end
    checks++;
    if (mem[5] !== 16'h1234) begin errors++; $display("FAIL write_a_ram: got %h expected 1234", mem[5]); end
    checks++;
    if (grant_b !== 1'b0) begin errors++; $display("FAIL write_a_grant: got %b expected 0", grant_b); end

    do_txn(1'b0, 1'b0, 3'd5, 16'h0000, lat, rd, loads, other);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL read_a_latency: got %0d expected 2", lat); end
    checks++;
    if (rd !== 16'h1234) begin errors++; $display("FAIL read_a_rdata: got %h expected 1234", rd); end
    checks++;
    if (loads !== 0) begin errors++; $display("FAIL read_a_load_cycles: got %0d expected 0", loads); end
    checks++;
    if (other !== 0) begin errors++; $display("FAIL read_a_stray_ack_b: got %0d expected 0", other); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL read_a_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_b_write_a_read();
    int lat, loads, other;
    logic [15:0] rd;
    do_txn(1'b1, 1'b1, 3'd7, 16'hBEEF, lat, rd, loads, other);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL write_b_latency: got %0d expected 2", lat); end
    checks++;
    if (rd !== 16'h0707) begin errors++; $display("FAIL write_b_rdata: got %h expected 0707", rd); end
    checks++;
    if (grant_b !== 1'b1) begin errors++; $display("FAIL write_b_grant: got %b expected 1", grant_b); end
    checks++;
    if (other !== 0) begin errors++; $display("FAIL write_b_stray_ack_a: got %0d expected 0", other); end

    do_txn(1'b0, 1'b0, 3'd7, 16'h0000, lat, rd, loads, other);
    checks++;
    if (rd !== 16'hBEEF) begin errors++; $display("FAIL read_a_after_b: got %h expected beef", rd); end
    checks++;
    if (rdata_b !== 16'h0707) begin errors++; $display("FAIL rdata_b_held: got %h expected 0707", rdata_b); end
  endtask

  task automatic test_reset_in_access();
    int lat, loads, other, acks;
    logic [15:0] rd;
    req_a = 1'b1; we_a = 1'b1; addr_a = 3'd3; wdata_a = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_access_busy: got %b expected 1", busy); end
    reset = 1'b1;
    req_a = 1'b0;
    #1;
    checks++;
    if (ram_load !== 1'b0) begin errors++; $display("FAIL rst_access_load: got %b expected 0", ram_load); end
    acks = 0;
    loads = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reset = 1'b0;
      if (ack_a || ack_b) acks++;
      if (ram_load) loads++;
    end
    checks++;
    if (acks !== 0 || loads !== 0) begin
      errors++;
      $display("FAIL rst_access_quiet: got acks=%0d loads=%0d expected 0 and 0", acks, loads);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_access_idle: got busy=%b expected 0", busy); end

    do_txn(1'b0, 1'b0, 3'd3, 16'h0000, lat, rd, loads, other);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL rst_access_readback: got %h expected 0000", rd); end
  endtask

  task automatic test_arbitration();
    logic exp_a, exp_b;
    int lat, loads, other;
    logic [15:0] rd;
    pulse_reset();
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 3'd2;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
`ifdef RAM8_ARB_RR_EN
      exp_a = (i == 2) || (i == 8);
      exp_b = (i == 5) || (i == 11);
`else
      exp_a = (i == 2) || (i == 5) || (i == 8) || (i == 11);
      exp_b = 1'b0;
`endif
      checks++;
      if ({ack_a, ack_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("FAIL arb_acks_cycle%0d: got a=%b b=%b expected a=%b b=%b", i, ack_a, ack_b, exp_a, exp_b);
      end
      if (exp_a) begin
        checks++;
        if (rdata_a !== 16'h1111) begin errors++; $display("FAIL arb_rdata_a_cycle%0d: got %h expected 1111", i, rdata_a); end
      end
      if (exp_b) begin
        checks++;
        if (rdata_b !== 16'h2222) begin errors++; $display("FAIL arb_rdata_b_cycle%0d: got %h expected 2222", i, rdata_b); end
      end
      if (i == 11) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL arb_drain_busy: got %b expected 0", busy); end

    // With A quiet, B is served at normal latency in either build.
    do_txn(1'b1, 1'b0, 3'd2, 16'h0000, lat, rd, loads, other);
    checks++;
    if (lat !== 2 || rd !== 16'h2222) begin
      errors++;
      $display("FAIL arb_b_alone: got lat=%0d rdata=%h expected lat=2 rdata=2222", lat, rd);
    end
  endtask

  task automatic test_back_to_back();
    int ack_a_at, ack_b_at;
    ack_a_at = -1;
    ack_b_at = -1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd5;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd7;
      end
      if (ack_a) begin
        ack_a_at = i;
        req_a = 1'b0;
        checks++;
        if (rdata_a !== 16'h1234) begin errors++; $display("FAIL b2b_rdata_a: got %h expected 1234", rdata_a); end
      end
      if (ack_b) begin
        ack_b_at = i;
        req_b = 1'b0;
        checks++;
        if (rdata_b !== 16'hBEEF) begin errors++; $display("FAIL b2b_rdata_b: got %h expected beef", rdata_b); end
        break;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    checks++;
    if (ack_a_at !== 2) begin errors++; $display("FAIL b2b_ack_a_cycle: got %0d expected 2", ack_a_at); end
    checks++;
    if (ack_b_at !== 5) begin errors++; $display("FAIL b2b_ack_b_cycle: got %0d expected 5", ack_b_at); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    we_a = 1'b0; we_b = 1'b0;
    addr_a = 3'd0; addr_b = 3'd0;
    wdata_a = 16'd0; wdata_b = 16'd0;

    test_reset();
    test_write_read_a();
    test_b_write_a_read();
    test_reset_in_access();
    test_arbitration();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
